// File: rtl/ap_line_ram.sv
// ApLine data-memory responder: BCD-addressed Brainfuck tape with a zero sweep
// after reset or Clear, registered BCD read data and sticky error flags.
module ap_line_ram #(
  parameter int AP_DEKATRON_NUM   = 5,
  parameter int DATA_DEKATRON_NUM = 3,
  parameter int DEKATRON_WIDTH    = 4,
  parameter int DEPTH             = 30000
) (
  input  logic                                        Clk,
  input  logic                                        Rst_n,
  input  logic                                        Clear,
  input  logic [AP_DEKATRON_NUM*DEKATRON_WIDTH-1:0]   Address,
  input  logic [DATA_DEKATRON_NUM*DEKATRON_WIDTH-1:0] RamDataIn,
  input  logic                                        RamWE,
  input  logic                                        RamCS,
  output logic [DATA_DEKATRON_NUM*DEKATRON_WIDTH-1:0] RamDataOut,
  output logic                                        Busy,
  output logic                                        AddrError,
  output logic                                        DataError
);

  localparam int AW = AP_DEKATRON_NUM * DEKATRON_WIDTH;
  localparam int DW = DATA_DEKATRON_NUM * DEKATRON_WIDTH;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEKATRON_WIDTH-1:0] NINE = DEKATRON_WIDTH'(9);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [31:0] addr_to_idx(input logic [AW-1:0] a);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = AP_DEKATRON_NUM - 1; i >= 0; i--)
      acc = acc * 32'd10 + 32'(a[i*DEKATRON_WIDTH +: DEKATRON_WIDTH]);
    return acc;
  endfunction

  function automatic logic addr_digits_ok(input logic [AW-1:0] a);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < AP_DEKATRON_NUM; i++)
      if (a[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] > NINE) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] data_to_val(input logic [DW-1:0] d);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = DATA_DEKATRON_NUM - 1; i >= 0; i--)
      acc = acc * 32'd10 + 32'(d[i*DEKATRON_WIDTH +: DEKATRON_WIDTH]);
    return acc;
  endfunction

  function automatic logic data_digits_ok(input logic [DW-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DATA_DEKATRON_NUM; i++)
      if (d[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] > NINE) ok = 1'b0;
    return ok;
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            aerr_q, aerr_d;
  logic            derr_q, derr_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic [31:0]     addr_idx_s;
  logic            addr_ok_s;
  logic            data_ok_s;
  logic [DW-1:0]   mem_rd_s;
  logic            mem_we_s;
  logic [IW-1:0]   mem_waddr_s;
  logic [DW-1:0]   mem_wdata_s;

  // Decode the BCD address and write data; cells are stored in BCD so reads stay well-formed.
  always_comb begin
    addr_idx_s = addr_to_idx(Address);
    addr_ok_s  = addr_digits_ok(Address) && (addr_idx_s < 32'(DEPTH));
    data_ok_s  = data_digits_ok(RamDataIn) && (data_to_val(RamDataIn) <= 32'd255);
    mem_rd_s   = mem_q[addr_idx_s[IW-1:0]];
  end

  // Next state: zero sweep in INIT, prioritised Clear/write/read handling in RUN.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dout_d      = dout_q;
    aerr_d      = aerr_q;
    derr_d      = derr_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = ptr_q;
    mem_wdata_s = {DW{1'b0}};
    case (state_q)
      ST_INIT: begin
        mem_we_s = 1'b1;
        dout_d   = {DW{1'b0}};
        if (Clear) begin
          ptr_d  = {IW{1'b0}};
          aerr_d = 1'b0;
          derr_d = 1'b0;
        end else if (ptr_q == IW'(DEPTH - 1)) begin
          ptr_d   = {IW{1'b0}};
          state_d = ST_RUN;
        end else begin
          ptr_d = ptr_q + IW'(1);
        end
      end
      ST_RUN: begin
        if (Clear) begin
          state_d = ST_INIT;
          ptr_d   = {IW{1'b0}};
          dout_d  = {DW{1'b0}};
          aerr_d  = 1'b0;
          derr_d  = 1'b0;
        end else if (RamCS && RamWE) begin
          if (!addr_ok_s) begin
            aerr_d = 1'b1;
            dout_d = {DW{1'b0}};
          end else if (!data_ok_s) begin
            derr_d = 1'b1;
            dout_d = mem_rd_s;
          end else begin
            mem_we_s    = 1'b1;
            mem_waddr_s = addr_idx_s[IW-1:0];
            mem_wdata_s = RamDataIn;
            dout_d      = RamDataIn;
          end
        end else if (RamCS) begin
          if (addr_ok_s) begin
            dout_d = mem_rd_s;
          end else begin
            dout_d = {DW{1'b0}};
            aerr_d = 1'b1;
          end
        end else begin
          dout_d = dout_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = {IW{1'b0}};
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= {IW{1'b0}};
      dout_q  <= {DW{1'b0}};
      aerr_q  <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      aerr_q  <= aerr_d;
      derr_q  <= derr_d;
    end
  end

  // Tape storage; contents are defined by the sweep, so no reset.
  always_ff @(posedge Clk) begin
    if (mem_we_s) mem_q[mem_waddr_s] <= mem_wdata_s;
  end

  assign RamDataOut = dout_q;
  assign Busy       = (state_q == ST_INIT);
  assign AddrError  = aerr_q;
  assign DataError  = derr_q;

endmodule

// File: tb/tb_ap_line_ram.sv
// Directed bench for ap_line_ram: a DEPTH=16 instance for sweep/Clear/reset
// behaviour and a full DEPTH=30000 instance for the top-of-range boundary.
module tb_ap_line_ram;
  logic        Clk;
  logic        r16_n, clr16, we16, cs16;
  logic [19:0] addr16;
  logic [11:0] din16, out16;
  logic        busy16, aerr16, derr16;
  logic        rb_n, clrb, web, csb;
  logic [19:0] addrb;
  logic [11:0] dinb, outb;
  logic        busyb, aerrb, derrb;
  int          n_cmp, n_err;

  ap_line_ram #(.DEPTH(16)) dut16 (
    .Clk(Clk), .Rst_n(r16_n), .Clear(clr16), .Address(addr16), .RamDataIn(din16),
    .RamWE(we16), .RamCS(cs16), .RamDataOut(out16), .Busy(busy16),
    .AddrError(aerr16), .DataError(derr16));

  ap_line_ram #(.DEPTH(30000)) dutb (
    .Clk(Clk), .Rst_n(rb_n), .Clear(clrb), .Address(addrb), .RamDataIn(dinb),
    .RamWE(web), .RamCS(csb), .RamDataOut(outb), .Busy(busyb),
    .AddrError(aerrb), .DataError(derrb));

  always #5 Clk = ~Clk;

  function automatic logic [19:0] bcd_addr(input int v);
    logic [19:0] r;
    int x;
    x = v;
    r = 20'h0;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic op16(input logic cs, input logic we, input logic [19:0] a,
                      input logic [11:0] d, input logic clr);
    @(negedge Clk);
    cs16 = cs; we16 = we; addr16 = a; din16 = d; clr16 = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle16();
    @(negedge Clk);
    cs16 = 1'b0; we16 = 1'b0; clr16 = 1'b0;
  endtask

  task automatic opb(input logic cs, input logic we, input logic [19:0] a, input logic [11:0] d);
    @(negedge Clk);
    csb = cs; web = we; addrb = a; dinb = d; clrb = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic busy_len16(output int cnt, output logic nz);
    cnt = 0;
    nz  = 1'b0;
    do begin
      @(posedge Clk);
      #1;
      cnt++;
      if (out16 !== 12'h000) nz = 1'b1;
    end while (busy16 === 1'b1 && cnt < 100);
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (busy16 !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", busy16); end
    n_cmp++; if (out16 !== 12'h000) begin n_err++; $display("FAIL rst_out: got %h want 000", out16); end
    n_cmp++; if ({aerr16, derr16} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {aerr16, derr16}); end
  endtask

  task automatic test_sweep();
    int cnt;
    logic nz;
    @(negedge Clk);
    r16_n = 1'b1;
    busy_len16(cnt, nz);
    n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL sweep_len: got %0d want 16", cnt); end
    n_cmp++; if (nz !== 1'b0) begin n_err++; $display("FAIL sweep_out: got nonzero want 000"); end
    for (int i = 0; i < 16; i++) begin
      op16(1'b1, 1'b0, bcd_addr(i), 12'h000, 1'b0);
      n_cmp++; if (out16 !== 12'h000) begin n_err++; $display("FAIL sweep_rd%0d: got %h want 000", i, out16); end
    end
    n_cmp++; if ({aerr16, derr16} !== 2'b00) begin n_err++; $display("FAIL sweep_flags: got %b want 00", {aerr16, derr16}); end
  endtask

  task automatic test_write_read();
    op16(1'b1, 1'b1, 20'h00012, 12'h255, 1'b0);
    n_cmp++; if (out16 !== 12'h255) begin n_err++; $display("FAIL wr12: got %h want 255", out16); end
    op16(1'b1, 1'b1, 20'h00011, 12'h000, 1'b0);
    n_cmp++; if (out16 !== 12'h000) begin n_err++; $display("FAIL wr11: got %h want 000", out16); end
    op16(1'b1, 1'b0, 20'h00012, 12'h000, 1'b0);
    n_cmp++; if (out16 !== 12'h255) begin n_err++; $display("FAIL rd12: got %h want 255", out16); end
    op16(1'b0, 1'b1, 20'h00011, 12'h999, 1'b0);
    n_cmp++; if (out16 !== 12'h255) begin n_err++; $display("FAIL cs0_hold: got %h want 255", out16); end
    op16(1'b1, 1'b0, 20'h00011, 12'h000, 1'b0);
    n_cmp++; if (out16 !== 12'h000) begin n_err++; $display("FAIL rd11: got %h want 000", out16); end
    n_cmp++; if ({aerr16, derr16} !== 2'b00) begin n_err++; $display("FAIL wr_flags: got %b want 00", {aerr16, derr16}); end
  endtask

  task automatic test_errors();
    op16(1'b1, 1'b1, 20'h00005, 12'h042, 1'b0);
    n_cmp++; if (out16 !== 12'h042) begin n_err++; $display("FAIL wr5: got %h want 042", out16); end
    op16(1'b1, 1'b1, 20'h00005, 12'h1A3, 1'b0);
    n_cmp++; if (out16 !== 12'h042) begin n_err++; $display("FAIL bad_nib_out: got %h want 042", out16); end
    n_cmp++; if (derr16 !== 1'b1) begin n_err++; $display("FAIL bad_nib_derr: got %b want 1", derr16); end
    op16(1'b1, 1'b0, 20'h00012, 12'h000, 1'b0);
    op16(1'b1, 1'b1, 20'h00005, 12'h256, 1'b0);
    n_cmp++; if (out16 !== 12'h042) begin n_err++; $display("FAIL over255_out: got %h want 042", out16); end
    op16(1'b1, 1'b0, 20'h00005, 12'h000, 1'b0);
    n_cmp++; if (out16 !== 12'h042) begin n_err++; $display("FAIL rd5: got %h want 042", out16); end
    n_cmp++; if (aerr16 !== 1'b0) begin n_err++; $display("FAIL aerr_early: got %b want 0", aerr16); end
    op16(1'b1, 1'b0, 20'h0000A, 12'h000, 1'b0);
    n_cmp++; if (out16 !== 12'h000) begin n_err++; $display("FAIL rdA_out: got %h want 000", out16); end
    n_cmp++; if (aerr16 !== 1'b1) begin n_err++; $display("FAIL rdA_aerr: got %b want 1", aerr16); end
    op16(1'b1, 1'b1, 20'h00015, 12'h099, 1'b0);
    n_cmp++; if (out16 !== 12'h099) begin n_err++; $display("FAIL wr15: got %h want 099", out16); end
    op16(1'b1, 1'b1, 20'h00016, 12'h011, 1'b0);
    n_cmp++; if (out16 !== 12'h000) begin n_err++; $display("FAIL wr16_out: got %h want 000", out16); end
  endtask

  task automatic test_clear();
    int cnt;
    logic nz;
    op16(1'b1, 1'b1, 20'h00003, 12'h077, 1'b1);
    n_cmp++; if (busy16 !== 1'b1) begin n_err++; $display("FAIL clr_busy: got %b want 1", busy16); end
    n_cmp++; if ({aerr16, derr16} !== 2'b00) begin n_err++; $display("FAIL clr_flags: got %b want 00", {aerr16, derr16}); end
    n_cmp++; if (out16 !== 12'h000) begin n_err++; $display("FAIL clr_out: got %h want 000", out16); end
    idle16();
    busy_len16(cnt, nz);
    n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL clr_len: got %0d want 16", cnt); end
    for (int i = 0; i < 16; i++) begin
      op16(1'b1, 1'b0, bcd_addr(i), 12'h000, 1'b0);
      n_cmp++; if (out16 !== 12'h000) begin n_err++; $display("FAIL clr_rd%0d: got %h want 000", i, out16); end
    end
  endtask

  task automatic test_async_reset();
    int cnt;
    logic nz;
    op16(1'b1, 1'b1, 20'h00001, 12'h123, 1'b0);
    op16(1'b1, 1'b0, 20'h0000F, 12'h000, 1'b0);
    op16(1'b1, 1'b1, 20'h00001, 12'h1FF, 1'b0);
    n_cmp++; if ({out16, aerr16, derr16} !== {12'h123, 2'b11}) begin n_err++; $display("FAIL pre_rst: got %h/%b%b want 123/11", out16, aerr16, derr16); end
    #2;
    r16_n = 1'b0;
    #1;
    n_cmp++; if ({busy16, out16, aerr16, derr16} !== {1'b1, 12'h000, 2'b00}) begin n_err++; $display("FAIL async_rst: got %b/%h/%b%b want 1/000/00", busy16, out16, aerr16, derr16); end
    @(negedge Clk);
    cs16 = 1'b0; we16 = 1'b0;
    r16_n = 1'b1;
    busy_len16(cnt, nz);
    n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL async_len: got %0d want 16", cnt); end
  endtask

  task automatic test_midsweep_reset();
    int cnt;
    logic nz;
    @(negedge Clk);
    r16_n = 1'b0;
    @(negedge Clk);
    r16_n = 1'b1;
    cs16 = 1'b1; we16 = 1'b1; addr16 = 20'h00002; din16 = 12'h055;
    repeat (7) @(posedge Clk);
    #2;
    r16_n = 1'b0;
    #1;
    n_cmp++; if ({busy16, out16} !== {1'b1, 12'h000}) begin n_err++; $display("FAIL mid_rst: got %b/%h want 1/000", busy16, out16); end
    @(negedge Clk);
    r16_n = 1'b1;
    busy_len16(cnt, nz);
    n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL mid_len: got %0d want 16", cnt); end
    n_cmp++; if (nz !== 1'b0) begin n_err++; $display("FAIL mid_out: got nonzero want 000"); end
    idle16();
    op16(1'b1, 1'b0, 20'h00002, 12'h000, 1'b0);
    n_cmp++; if (out16 !== 12'h000) begin n_err++; $display("FAIL busy_wr_drop: got %h want 000", out16); end
  endtask

  task automatic test_big_depth();
    int cnt;
    @(negedge Clk);
    rb_n = 1'b1;
    cnt = 0;
    do begin
      @(posedge Clk);
      #1;
      cnt++;
    end while (busyb === 1'b1 && cnt < 31000);
    n_cmp++; if (cnt !== 30000) begin n_err++; $display("FAIL big_len: got %0d want 30000", cnt); end
    opb(1'b1, 1'b1, 20'h29999, 12'h128);
    n_cmp++; if ({outb, aerrb} !== {12'h128, 1'b0}) begin n_err++; $display("FAIL wr29999: got %h/%b want 128/0", outb, aerrb); end
    opb(1'b1, 1'b1, 20'h30000, 12'h077);
    n_cmp++; if ({outb, aerrb} !== {12'h000, 1'b1}) begin n_err++; $display("FAIL wr30000: got %h/%b want 000/1", outb, aerrb); end
    opb(1'b1, 1'b0, 20'h00000, 12'h000);
    n_cmp++; if (outb !== 12'h000) begin n_err++; $display("FAIL big_rd0: got %h want 000", outb); end
    opb(1'b1, 1'b0, 20'h29999, 12'h000);
    n_cmp++; if ({outb, aerrb, derrb} !== {12'h128, 1'b1, 1'b0}) begin n_err++; $display("FAIL rd29999: got %h/%b%b want 128/10", outb, aerrb, derrb); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    Clk = 1'b0;
    r16_n = 1'b0; clr16 = 1'b0; we16 = 1'b0; cs16 = 1'b0; addr16 = 20'h0; din16 = 12'h0;
    rb_n = 1'b0; clrb = 1'b0; web = 1'b0; csb = 1'b0; addrb = 20'h0; dinb = 12'h0;
    test_reset();
    test_sweep();
    test_write_read();
    test_errors();
    test_clear();
    test_async_reset();
    test_midsweep_reset();
    test_big_depth();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
